// File: rtl/lsu_mem_port.sv
// Load/store front-end for memory port B. It takes one request at a time,
// drives the aligned word access for one cycle, and absorbs the 1-cycle read
// latency. It returns the extended load data or a fault over valid/ready.
module lsu_mem_port #(
   parameter  int unsigned MEM_SIZE = 8192,
   localparam int unsigned ADDR_W   = $clog2(MEM_SIZE)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [31:0]       req_addr,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [31:0]       resp_rdata,
   output logic              resp_fault,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   output logic [3:0]        mem_data_en,
   output logic              mem_write_en
);

   typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

   state_t            state_q, state_d;
   logic              we_q, we_d;
   logic [1:0]        size_q, size_d;
   logic              uns_q, uns_d;
   logic [1:0]        off_q, off_d;
   logic [ADDR_W-1:0] maddr_q, maddr_d;
   logic [31:0]       mwdata_q, mwdata_d;
   logic [3:0]        men_q, men_d;
   logic              mwe_q, mwe_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              fault_q, fault_d;

   logic              accept;
   logic              fault_c;
   logic [3:0]        lane_en;
   logic [31:0]       lane_wdata;
   logic [31:0]       load_ext;
   logic [7:0]        ld_byte;
   logic [15:0]       ld_half;

   assign accept = req_valid && (state_q == IDLE);

   // Request decode: fault detection, byte enables, and lane-replicated store data
   always_comb begin
      fault_c    = (req_addr[31:ADDR_W] != '0);
      lane_en    = 4'b1111;
      lane_wdata = req_wdata;
      unique case (req_size)
         2'b00: begin
            lane_en    = 4'b0001 << req_addr[1:0];
            lane_wdata = {4{req_wdata[7:0]}};
         end
         2'b01: begin
            fault_c    = fault_c || req_addr[0];
            lane_en    = 4'b0011 << {req_addr[1], 1'b0};
            lane_wdata = {2{req_wdata[15:0]}};
         end
         2'b10: fault_c = fault_c || (req_addr[1:0] != 2'b00);
         default: fault_c = 1'b1;
      endcase
   end

   // Load lane selection and sign/zero extension of the word returned by memory
   always_comb begin
      ld_byte  = mem_rdata[{off_q, 3'b000} +: 8];
      ld_half  = mem_rdata[{off_q[1], 4'b0000} +: 16];
      load_ext = mem_rdata;
      unique case (size_q)
         2'b00:   load_ext = uns_q ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
         2'b01:   load_ext = uns_q ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
         default: load_ext = mem_rdata;
      endcase
   end

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // FSM next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept) state_d = fault_c ? RESP : ISSUE;
         ISSUE:   state_d = CAPTURE;
         CAPTURE: state_d = RESP;
         RESP:    if (resp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM output decode: handshake flags depend on state only
   always_comb begin
      req_ready  = (state_q == IDLE);
      resp_valid = (state_q == RESP);
   end

   // Datapath next-state: latch the request, run the memory strobe, then capture the result
   always_comb begin
      we_d     = we_q;
      size_d   = size_q;
      uns_d    = uns_q;
      off_d    = off_q;
      maddr_d  = maddr_q;
      mwdata_d = mwdata_q;
      men_d    = men_q;
      mwe_d    = mwe_q;
      rdata_d  = rdata_q;
      fault_d  = fault_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               we_d   = req_we;
               size_d = req_size;
               uns_d  = req_unsigned;
               off_d  = req_addr[1:0];
               if (fault_c) begin
                  fault_d = 1'b1;
                  rdata_d = '0;
               end else begin
                  maddr_d  = {req_addr[ADDR_W-1:2], 2'b00};
                  men_d    = lane_en;
                  mwe_d    = req_we;
                  mwdata_d = lane_wdata;
               end
            end
         end
         ISSUE: begin
            men_d = '0;
            mwe_d = 1'b0;
         end
         CAPTURE: rdata_d = we_q ? '0 : load_ext;
         RESP: begin
            if (resp_ready) begin
               fault_d = 1'b0;
               rdata_d = '0;
            end
         end
         default: ;
      endcase
   end

   // Datapath registers; async reset drops the write strobe and enables together
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         we_q     <= 1'b0;
         size_q   <= '0;
         uns_q    <= 1'b0;
         off_q    <= '0;
         maddr_q  <= '0;
         mwdata_q <= '0;
         men_q    <= '0;
         mwe_q    <= 1'b0;
         rdata_q  <= '0;
         fault_q  <= 1'b0;
      end else begin
         we_q     <= we_d;
         size_q   <= size_d;
         uns_q    <= uns_d;
         off_q    <= off_d;
         maddr_q  <= maddr_d;
         mwdata_q <= mwdata_d;
         men_q    <= men_d;
         mwe_q    <= mwe_d;
         rdata_q  <= rdata_d;
         fault_q  <= fault_d;
      end
   end

   assign mem_addr     = maddr_q;
   assign mem_wdata    = mwdata_q;
   assign mem_data_en  = men_q;
   assign mem_write_en = mwe_q;
   assign resp_rdata   = rdata_q;
   assign resp_fault   = fault_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Bench for lsu_mem_port: a behavioural synchronous BRAM on port B, a table of
// request vectors with per-cycle protocol checks, and a response scoreboard.
module tb_lsu_mem_port;

   localparam int unsigned MEM_SIZE = 8192;
   localparam int unsigned ADDR_W   = 13;

   logic              clk = 1'b0;
   logic              rst;
   logic              req_valid, req_ready;
   logic [31:0]       req_addr;
   logic              req_we;
   logic [1:0]        req_size;
   logic              req_unsigned;
   logic [31:0]       req_wdata;
   logic              resp_valid, resp_ready;
   logic [31:0]       resp_rdata;
   logic              resp_fault;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata, mem_rdata;
   logic [3:0]        mem_data_en;
   logic              mem_write_en;

   int unsigned n_total = 0;
   int unsigned n_pass  = 0;

   lsu_mem_port #(.MEM_SIZE(MEM_SIZE)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
      .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_fault(resp_fault),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_data_en(mem_data_en), .mem_write_en(mem_write_en)
   );

   always #5 clk = ~clk;

   // Behavioural BRAM: byte-enabled write, registered read (old data)
   logic [31:0] mem [2048];
   logic [31:0] mem_merge;
   always_comb begin
      mem_merge = mem[mem_addr[12:2]];
      for (int b = 0; b < 4; b++)
         if (mem_data_en[b]) mem_merge[8*b +: 8] = mem_wdata[8*b +: 8];
   end
   always @(posedge clk) begin
      if (mem_write_en) mem[mem_addr[12:2]] <= mem_merge;
      mem_rdata <= mem[mem_addr[12:2]];
   end

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endfunction

   typedef struct {
      logic [31:0] rdata;
      logic        fault;
   } exp_t;
   exp_t sbq[$];
   exp_t sb_e;

   // Response scoreboard: compare each accepted response with the oldest expectation
   always @(negedge clk) begin
      if (!rst && resp_valid && resp_ready) begin
         if (sbq.size() == 0) begin
            n_total++;
            $display("FAIL sb_unexpected: got response %h with no pending request", resp_rdata);
         end else begin
            sb_e = sbq.pop_front();
            check("resp_rdata", resp_rdata, sb_e.rdata);
            check("resp_fault", 32'(resp_fault), 32'(sb_e.fault));
         end
      end
   end

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  exp_en;
      logic [31:0] exp_mwdata;
      logic [31:0] exp_rdata;
      logic        exp_fault;
   } vec_t;
   vec_t vecs[$];

   function automatic vec_t mk(logic we, logic [1:0] size, logic uns, logic [31:0] addr,
                               logic [31:0] wdata, logic [3:0] en, logic [31:0] mwdata,
                               logic [31:0] rdata, logic fault);
      vec_t v;
      v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
      v.exp_en = en; v.exp_mwdata = mwdata; v.exp_rdata = rdata; v.exp_fault = fault;
      return v;
   endfunction

   task automatic drive(input vec_t v);
      req_we       = v.we;
      req_size     = v.size;
      req_unsigned = v.uns;
      req_addr     = v.addr;
      req_wdata    = v.wdata;
      req_valid    = 1'b1;
   endtask

   task automatic scramble();
      req_valid    = 1'b0;
      req_addr     = $urandom;
      req_wdata    = $urandom;
      req_we       = 1'($urandom_range(1));
      req_size     = 2'($urandom_range(3));
      req_unsigned = 1'($urandom_range(1));
   endtask

   // One full request with exact-latency checks; stall holds resp_ready low in RESP
   task automatic run_req(input vec_t v, input int unsigned stall);
      exp_t        e;
      logic [12:0] ea;
      resp_ready = (stall == 0);
      @(negedge clk);
      check("req_ready_idle", 32'(req_ready), 32'd1);
      drive(v);
      @(posedge clk);
      e.rdata = v.exp_rdata;
      e.fault = v.exp_fault;
      sbq.push_back(e);
      #1;
      scramble();
      if (v.exp_fault) begin
         check("fault_resp_valid", 32'(resp_valid), 32'd1);
         check("fault_no_write", 32'(mem_write_en), 32'd0);
      end else begin
         ea = v.addr[12:0] & 13'h1FFC;
         check("issue_mem_addr", 32'(mem_addr), 32'(ea));
         check("issue_data_en", 32'(mem_data_en), 32'(v.exp_en));
         check("issue_write_en", 32'(mem_write_en), 32'(v.we));
         check("issue_mem_wdata", mem_wdata, v.exp_mwdata);
         check("issue_resp_valid", 32'(resp_valid), 32'd0);
         @(posedge clk); #1;
         check("capture_write_en", 32'(mem_write_en), 32'd0);
         check("capture_data_en", 32'(mem_data_en), 32'd0);
         check("capture_resp_valid", 32'(resp_valid), 32'd0);
         @(posedge clk); #1;
         check("resp_valid_latency", 32'(resp_valid), 32'd1);
      end
      check("req_ready_busy", 32'(req_ready), 32'd0);
      for (int unsigned i = 0; i < stall; i++) begin
         @(posedge clk); #1;
         check("stall_resp_valid", 32'(resp_valid), 32'd1);
         check("stall_resp_rdata", resp_rdata, v.exp_rdata);
         check("stall_req_ready", 32'(req_ready), 32'd0);
         req_valid = 1'b1;
         req_addr  = $urandom & 32'h0000_1FFC;
      end
      req_valid  = 1'b0;
      resp_ready = 1'b1;
      @(posedge clk); #1;
      check("idle_resp_valid", 32'(resp_valid), 32'd0);
      check("idle_resp_rdata", resp_rdata, 32'd0);
      check("idle_resp_fault", 32'(resp_fault), 32'd0);
      check("idle_req_ready", 32'(req_ready), 32'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
      check({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
      check({tag, "_resp_fault"}, 32'(resp_fault), 32'd0);
      check({tag, "_resp_rdata"}, resp_rdata, 32'd0);
      check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
      check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
      check({tag, "_data_en"}, 32'(mem_data_en), 32'd0);
      check({tag, "_write_en"}, 32'(mem_write_en), 32'd0);
   endtask

   initial begin
      rst = 1'b1;
      resp_ready = 1'b1;
      req_valid = 1'b0;
      req_addr = '0; req_wdata = '0; req_we = 1'b0; req_size = '0; req_unsigned = 1'b0;
      #2;
      check_reset_outputs("reset");
      @(negedge clk);
      rst = 1'b0;

      //              we    size  uns   addr           wdata          en       mwdata         rdata          fault
      vecs.push_back(mk(1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF, 32'h0,         1'b0));
      vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0,         4'b1111, 32'h0,         32'hDEAD_BEEF, 1'b0));
      vecs.push_back(mk(1'b1, 2'b10, 1'b0, 32'h0000_0020, 32'h80FF_7F01, 4'b1111, 32'h80FF_7F01, 32'h0,         1'b0));
      vecs.push_back(mk(1'b0, 2'b00, 1'b0, 32'h0000_0021, 32'h0,         4'b0010, 32'h0,         32'h0000_007F, 1'b0));
      vecs.push_back(mk(1'b0, 2'b00, 1'b0, 32'h0000_0023, 32'h0,         4'b1000, 32'h0,         32'hFFFF_FF80, 1'b0));
      vecs.push_back(mk(1'b0, 2'b00, 1'b1, 32'h0000_0023, 32'h0,         4'b1000, 32'h0,         32'h0000_0080, 1'b0));
      vecs.push_back(mk(1'b0, 2'b01, 1'b0, 32'h0000_0022, 32'h0,         4'b1100, 32'h0,         32'hFFFF_80FF, 1'b0));
      vecs.push_back(mk(1'b0, 2'b01, 1'b1, 32'h0000_0022, 32'h0,         4'b1100, 32'h0,         32'h0000_80FF, 1'b0));
      vecs.push_back(mk(1'b0, 2'b00, 1'b1, 32'h0000_0020, 32'h0,         4'b0001, 32'h0,         32'h0000_0001, 1'b0));
      vecs.push_back(mk(1'b0, 2'b01, 1'b0, 32'h0000_0020, 32'h0,         4'b0011, 32'h0,         32'h0000_7F01, 1'b0));
      vecs.push_back(mk(1'b0, 2'b00, 1'b0, 32'h0000_0022, 32'h0,         4'b0100, 32'h0,         32'hFFFF_FFFF, 1'b0));
      vecs.push_back(mk(1'b0, 2'b10, 1'b1, 32'h0000_0020, 32'h0,         4'b1111, 32'h0,         32'h80FF_7F01, 1'b0));
      vecs.push_back(mk(1'b1, 2'b10, 1'b0, 32'h0000_0030, 32'h1122_3344, 4'b1111, 32'h1122_3344, 32'h0,         1'b0));
      vecs.push_back(mk(1'b1, 2'b00, 1'b0, 32'h0000_0031, 32'h0000_00AA, 4'b0010, 32'hAAAA_AAAA, 32'h0,         1'b0));
      vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h0000_0030, 32'h0,         4'b1111, 32'h0,         32'h1122_AA44, 1'b0));
      vecs.push_back(mk(1'b1, 2'b01, 1'b0, 32'h0000_0032, 32'h0000_BEEF, 4'b1100, 32'hBEEF_BEEF, 32'h0,         1'b0));
      vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h0000_0030, 32'h0,         4'b1111, 32'h0,         32'hBEEF_AA44, 1'b0));
      vecs.push_back(mk(1'b1, 2'b01, 1'b0, 32'h0000_0030, 32'hFFFF_1234, 4'b0011, 32'h1234_1234, 32'h0,         1'b0));
      vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h0000_0030, 32'h0,         4'b1111, 32'h0,         32'hBEEF_1234, 1'b0));
      vecs.push_back(mk(1'b1, 2'b10, 1'b0, 32'h0000_1FFC, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D, 32'h0,         1'b0));
      vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h0000_1FFC, 32'h0,         4'b1111, 32'h0,         32'hCAFE_F00D, 1'b0));
      vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h0000_0013, 32'h0,         4'b0000, 32'h0,         32'h0,         1'b1));
      vecs.push_back(mk(1'b0, 2'b01, 1'b0, 32'h0000_0041, 32'h0,         4'b0000, 32'h0,         32'h0,         1'b1));
      vecs.push_back(mk(1'b0, 2'b11, 1'b0, 32'h0000_0040, 32'h0,         4'b0000, 32'h0,         32'h0,         1'b1));
      vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h0000_2000, 32'h0,         4'b0000, 32'h0,         32'h0,         1'b1));
      vecs.push_back(mk(1'b1, 2'b10, 1'b0, 32'h0000_0012, 32'h5555_5555, 4'b0000, 32'h0,         32'h0,         1'b1));
      vecs.push_back(mk(1'b1, 2'b00, 1'b0, 32'h8000_0010, 32'h0000_0066, 4'b0000, 32'h0,         32'h0,         1'b1));
      vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0,         4'b1111, 32'h0,         32'hDEAD_BEEF, 1'b0));

      foreach (vecs[i]) run_req(vecs[i], 0);

      // Backpressure: response held for 5 cycles, stray req_valid pulses ignored
      run_req(mk(1'b0, 2'b01, 1'b1, 32'h0000_0022, 32'h0, 4'b1100, 32'h0, 32'h0000_80FF, 1'b0), 5);
      run_req(mk(1'b0, 2'b10, 1'b0, 32'h0000_0013, 32'h0, 4'b0000, 32'h0, 32'h0,         1'b1), 3);
      run_req(mk(1'b0, 2'b10, 1'b0, 32'h0000_0020, 32'h0, 4'b1111, 32'h0, 32'h80FF_7F01, 1'b0), 0);

      // Reset while a store is in ISSUE: strobe drops before the edge, word keeps old value
      @(negedge clk);
      drive(mk(1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'h1111_1111, 4'b1111, 32'h1111_1111, 32'h0, 1'b0));
      @(posedge clk); #1;
      scramble();
      check("rst_issue_we_before", 32'(mem_write_en), 32'd1);
      #2 rst = 1'b1;
      #1;
      check_reset_outputs("rst_issue");
      @(negedge clk);
      rst = 1'b0;
      run_req(mk(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0, 4'b1111, 32'h0, 32'hDEAD_BEEF, 1'b0), 0);

      // Reset while a response is pending: it is discarded
      resp_ready = 1'b0;
      @(negedge clk);
      drive(mk(1'b0, 2'b10, 1'b0, 32'h0000_0030, 32'h0, 4'b1111, 32'h0, 32'h0, 1'b0));
      @(posedge clk); #1;
      scramble();
      @(posedge clk);
      @(posedge clk); #1;
      check("rst_resp_valid_before", 32'(resp_valid), 32'd1);
      check("rst_resp_rdata_before", resp_rdata, 32'hBEEF_1234);
      rst = 1'b1;
      #1;
      check_reset_outputs("rst_resp");
      @(negedge clk);
      rst = 1'b0;
      resp_ready = 1'b1;
      @(posedge clk); #1;
      check("rst_resp_discarded", 32'(resp_valid), 32'd0);

      check("sb_drained", 32'(sbq.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
